// File: rtl/jesd_pkg.sv
// Shared JESD204B receive-path types and helpers: CGS state encoding,
// the K28.5 comma code and small saturating arithmetic functions.
package jesd_pkg;

  typedef enum logic [1:0] {
    CS_INIT  = 2'd0,
    CS_CHECK = 2'd1,
    CS_DATA  = 2'd2
  } cgs_state_e;

  localparam logic [7:0] K28_5 = 8'hBC;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [7:0] popcount32(input logic [31:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {7'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/cgs_octet_classify.sv
// Per-cycle octet classification: K28.5 detection, error flags, invalid
// count and the length of the K run ending at the newest octet.
module cgs_octet_classify
  import jesd_pkg::*;
#(
  parameter int PARALLEL_OCTETS = 4
) (
  input  logic [8*PARALLEL_OCTETS-1:0] rx_data_i,
  input  logic [PARALLEL_OCTETS-1:0]   rx_charisk_i,
  input  logic [PARALLEL_OCTETS-1:0]   rx_notintable_i,
  input  logic [PARALLEL_OCTETS-1:0]   rx_disperr_i,
  output logic [PARALLEL_OCTETS-1:0]   is_k,
  output logic [PARALLEL_OCTETS-1:0]   invalid,
  output logic                         all_k,
  output logic [7:0]                   n_inv,
  output logic [7:0]                   k_trail
);

  always_comb begin
    for (int i = 0; i < PARALLEL_OCTETS; i++) begin
      invalid[i] = rx_notintable_i[i] | rx_disperr_i[i];
      is_k[i]    = rx_charisk_i[i] & (rx_data_i[8*i +: 8] == K28_5) & ~invalid[i];
    end
  end

  assign all_k = &is_k;
  assign n_inv = popcount32(32'(invalid));

  // Count K octets contiguous from the newest (highest) octet downward.
  always_comb begin
    logic run;
    k_trail = '0;
    run     = 1'b1;
    for (int i = PARALLEL_OCTETS - 1; i >= 0; i--) begin
      if (run && is_k[i]) k_trail = k_trail + 8'd1;
      else                run     = 1'b0;
    end
  end

endmodule

// File: rtl/cgs_detector.sv
// Per-lane JESD204B code group synchronization detector running the
// CS_INIT / CS_CHECK / CS_DATA state machine on decoded GT octets.
module cgs_detector
  import jesd_pkg::*;
#(
  parameter int PARALLEL_OCTETS = 4,
  parameter int K_MIN           = 4,
  parameter int INV_MAX         = 3,
  parameter int CHECK_CYCLES    = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cgs_rst_i,
  input  logic [8*PARALLEL_OCTETS-1:0] rx_data_i,
  input  logic [PARALLEL_OCTETS-1:0]   rx_charisk_i,
  input  logic [PARALLEL_OCTETS-1:0]   rx_notintable_i,
  input  logic [PARALLEL_OCTETS-1:0]   rx_disperr_i,
  output logic                         cgs_detected_o,
  output logic [1:0]                   cgs_state_o,
  output logic [7:0]                   inv_err_ctr_o
);

  localparam logic [7:0] K_MIN_C   = 8'(K_MIN);
  localparam logic [7:0] INV_MAX_C = 8'(INV_MAX);
  localparam logic [7:0] CHECK_C   = 8'(CHECK_CYCLES);
  localparam logic [7:0] OCTETS_C  = 8'(PARALLEL_OCTETS);

  logic [PARALLEL_OCTETS-1:0] is_k, invalid;
  logic                       all_k;
  logic [7:0]                 n_inv, k_trail;

  cgs_octet_classify #(.PARALLEL_OCTETS(PARALLEL_OCTETS)) u_classify (
    .rx_data_i       (rx_data_i),
    .rx_charisk_i    (rx_charisk_i),
    .rx_notintable_i (rx_notintable_i),
    .rx_disperr_i    (rx_disperr_i),
    .is_k            (is_k),
    .invalid         (invalid),
    .all_k           (all_k),
    .n_inv           (n_inv),
    .k_trail         (k_trail)
  );

  cgs_state_e state_q, state_d;
  logic [7:0] k_run_q, k_run_d, inv_ctr_q, inv_ctr_d, good_ctr_q, good_ctr_d;
  logic [7:0] inv_err_q;
  logic [7:0] k_scan, k_run_nxt, inv_sum, good_sum;
  logic       k_hit;

  // Walk the octets oldest-first so a run carried in from the previous
  // cycle is detected even when it ends partway through this one.
  always_comb begin
    k_scan = k_run_q;
    k_hit  = 1'b0;
    for (int i = 0; i < PARALLEL_OCTETS; i++) begin
      k_scan = is_k[i] ? sat_add8(k_scan, 8'd1) : 8'd0;
      if (k_scan >= K_MIN_C) k_hit = 1'b1;
    end
    k_run_nxt = all_k ? sat_add8(k_run_q, OCTETS_C) : k_trail;
  end

  assign inv_sum  = sat_add8(inv_ctr_q, n_inv);
  assign good_sum = sat_add8(good_ctr_q, 8'd1);

  always_comb begin
    state_d    = state_q;
    k_run_d    = k_run_q;
    inv_ctr_d  = inv_ctr_q;
    good_ctr_d = good_ctr_q;
    case (state_q)
      CS_INIT: begin
        if (k_hit) begin
          state_d    = CS_CHECK;
          k_run_d    = '0;
          inv_ctr_d  = '0;
          good_ctr_d = '0;
        end else begin
          k_run_d = k_run_nxt;
        end
      end
      CS_CHECK: begin
        if (n_inv != 8'd0) begin
          inv_ctr_d  = inv_sum;
          good_ctr_d = '0;
          if (inv_sum >= INV_MAX_C) begin
            state_d = CS_INIT;
            k_run_d = '0;
          end
        end else begin
          good_ctr_d = good_sum;
          if (good_sum == CHECK_C) state_d = CS_DATA;
        end
      end
      CS_DATA: begin
        if (n_inv != 8'd0) begin
          good_ctr_d = '0;
          if (n_inv >= INV_MAX_C) begin
            state_d = CS_INIT;
            k_run_d = '0;
          end else begin
            state_d   = CS_CHECK;
            inv_ctr_d = n_inv;
          end
        end
      end
      default: begin
        state_d    = CS_INIT;
        k_run_d    = '0;
        inv_ctr_d  = '0;
        good_ctr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || cgs_rst_i) begin
      state_q    <= CS_INIT;
      k_run_q    <= '0;
      inv_ctr_q  <= '0;
      good_ctr_q <= '0;
      inv_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      k_run_q    <= k_run_d;
      inv_ctr_q  <= inv_ctr_d;
      good_ctr_q <= good_ctr_d;
      inv_err_q  <= sat_add8(inv_err_q, n_inv);
    end
  end

  assign cgs_state_o    = state_q;
  assign cgs_detected_o = (state_q == CS_CHECK) || (state_q == CS_DATA);
  assign inv_err_ctr_o  = inv_err_q;

endmodule
